genius_round_ctrl: RTL and testbench
====================================

Name: genius_round_ctrl

Overview:
- Game-sequence controller for the Genius (Simon) game. It generates the colour sequence, plays it on the LEDs, checks the player's button presses, and advances the round count.
- Its registered ROUND output feeds the points stage directly (POINTS = level x ROUND). It sits between the button/debounce front end and the scoring logic.
- It also reports win/lose status to the top-level display.

Parameters:
- MAX_ROUND, 15, round count that wins the game (1..15; ROUND is 4 bits).
- TICKS_ON, 25_000_000, cycles each colour LED is lit during playback.
- TICKS_OFF, 12_500_000, dark gap between played colours.
- TIMEOUT, 250_000_000, cycles allowed in WAIT_IN with no press before losing.

Ports:
- CLOCK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- START  in  1  single-cycle pulse; starts a new game.
- SEED  in  8  LFSR seed, latched on an accepted START.
- BTN_VALID  in  1  single-cycle pulse, debounced player press.
- BTN_CODE  in  2  colour of the press (00 green, 01 red, 10 yellow, 11 blue).
- LED  out  4  one-hot playback drive; bit n lit for colour n.
- ROUND  out  4  current sequence length; consumed by the scoring stage.
- ROUND_DONE  out  1  one-cycle pulse when a full round is entered correctly.
- PLAYING  out  1  high in every state except IDLE/WIN/LOSE.
- WIN  out  1  level, high in WIN state.
- LOSE  out  1  level, high in LOSE state.

Behaviour:
- Reset (RESET=0 at an edge): state IDLE. LED=0, ROUND=0, ROUND_DONE=0, PLAYING=0, WIN=0, LOSE=0, idx=0, tick counter=0, LFSR=8'hA5.
  - Applies from any state, mid-playback included.
  - Sequence storage contents are don't-care.
- LFSR: 8-bit Fibonacci, shift left, new bit0 = b7^b5^b4^b3.
  - Seed 8'h00 is replaced by 8'hA5.
  - The colour taken is lfsr[1:0] before the advance.
- Storage: 16 x 2-bit registers seq[0..15].
- States: IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
- IDLE/WIN/LOSE, on START=1:
  - Load LFSR from SEED; ROUND<=0; WIN<=0; LOSE<=0.
  - Next state APPEND.
  - START in any other state is ignored.
- APPEND (1 cycle):
  - seq[ROUND]<=lfsr[1:0]; LFSR advances; ROUND<=ROUND+1; idx<=0; tick<=0.
  - Next state SHOW_ON.
- SHOW_ON: LED=onehot(seq[idx]) for exactly TICKS_ON cycles, then SHOW_OFF with tick reset.
- SHOW_OFF: LED=0 for exactly TICKS_OFF cycles, then idx<=idx+1.
  - If idx+1==ROUND: idx<=0, tick<=0, go to WAIT_IN.
  - Otherwise return to SHOW_ON.
- LED is registered and is 0 in every state other than SHOW_ON.
- WAIT_IN: tick counts cycles since entry or since the last accepted press.
  - BTN_VALID with BTN_CODE==seq[idx] and idx<ROUND-1: idx<=idx+1, tick<=0.
  - BTN_VALID with a match and idx==ROUND-1: ROUND_DONE=1 for the next cycle. If ROUND==MAX_ROUND go to WIN, else go to APPEND.
  - BTN_VALID with a mismatch: go to LOSE.
  - tick reaching TIMEOUT with no press: go to LOSE. If BTN_VALID arrives in the same cycle as the timeout, the press wins.
- BTN_VALID outside WAIT_IN is ignored; presses during playback are discarded.
- WIN/LOSE: ROUND holds its final value so the score stays valid; PLAYING=0.
- ROUND changes only in APPEND, on START acceptance, or on reset. It never wraps, since MAX_ROUND<=15.
- Counter widths are sized by $clog2 of the largest of TICKS_ON, TICKS_OFF and TIMEOUT.

Decomposition:
- Package genius_pkg holds:
  - state enum;
  - colour codes;
  - one-hot decode function;
  - LFSR_TAPS, LFSR_DEFAULT_SEED=8'hA5;
  - ROUND_W=4.
- One natural sub-module, genius_lfsr8, with ports CLOCK, RESET, load, seed, advance, value. The FSM, storage and counters stay in genius_round_ctrl.

Test Plan (TICKS_ON=2, TICKS_OFF=1, TIMEOUT=20, MAX_ROUND=3):
- START with SEED=8'h01 -> APPEND on the next cycle, ROUND=1. Then LED=4'b0010 for 2 cycles, LED=0 for 1 cycle, then WAIT_IN with PLAYING=1.
- Press 01 in WAIT_IN -> ROUND_DONE pulses once and ROUND=2. Playback shows 4'b0010, 0, 4'b0100, 0 with the specified cycle counts (seq = 01,10).
- Complete 3 rounds correctly (colours 01,10,00) -> WIN=1, PLAYING=0, ROUND=3 held. A later START clears WIN and gives ROUND=1.
- In round 2, press 10 as the first colour -> LOSE=1 on the next cycle, ROUND stays 2, further BTN_VALID ignored.
- No press for 20 cycles in WAIT_IN -> LOSE=1. A press arriving on the timeout cycle with the correct code is accepted instead.
- RESET=0 during SHOW_ON of round 2 -> next cycle LED=0, ROUND=0, IDLE. SEED=8'h00 on a new START plays colour 01 (from 8'hA5).

Source files
------------

// File: rtl/genius_pkg.sv
// ---- genius_pkg : shared types and constants for the Genius round controller (rev 1.0) ----
`default_nettype none

package genius_pkg;

  localparam int         ROUND_W           = 4;
  localparam int         SEQ_DEPTH         = 16;
  localparam logic [7:0] LFSR_TAPS         = 8'b1011_1000;
  localparam logic [7:0] LFSR_DEFAULT_SEED = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_APPEND   = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_WAIT_IN  = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    COL_GREEN  = 2'd0,
    COL_RED    = 2'd1,
    COL_YELLOW = 2'd2,
    COL_BLUE   = 2'd3
  } colour_e;

  function automatic logic [3:0] colour_onehot(input logic [1:0] c);
    colour_onehot = 4'b0001 << c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/genius_lfsr8.sv
// ---- genius_lfsr8 : 8-bit Fibonacci LFSR, seedable, zero seed replaced (rev 1.0) ----
`default_nettype none

module genius_lfsr8
  import genius_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      // An all-zero state would lock the register up, so it is never loaded.
      value_d = (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
    end else if (advance) begin
      value_d = {value_q[6:0], ^(value_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) value_q <= LFSR_DEFAULT_SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/genius_round_ctrl.sv
// ---- genius_round_ctrl : Simon sequence generation, playback, input check, round count (rev 1.0) ----
`default_nettype none

module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_ROUND = 15,
  parameter int TICKS_ON  = 25_000_000,
  parameter int TICKS_OFF = 12_500_000,
  parameter int TIMEOUT   = 250_000_000
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic [7:0]         SEED,
  input  logic               BTN_VALID,
  input  logic [1:0]         BTN_CODE,
  output logic [3:0]         LED,
  output logic [ROUND_W-1:0] ROUND,
  output logic               ROUND_DONE,
  output logic               PLAYING,
  output logic               WIN,
  output logic               LOSE
);

  localparam int CNT_MAX = (TICKS_ON > TICKS_OFF)
                         ? ((TICKS_ON  > TIMEOUT) ? TICKS_ON  : TIMEOUT)
                         : ((TICKS_OFF > TIMEOUT) ? TICKS_OFF : TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   ON_LAST   = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0]   OFF_LAST  = CNT_W'(TICKS_OFF - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(MAX_ROUND);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   tick_q, tick_d;
  logic [3:0]         led_q, led_d;
  logic               done_q, done_d;
  logic [1:0]         seq_q [SEQ_DEPTH];

  logic [7:0] lfsr_value;
  logic       lfsr_unused;
  logic       start_ok;
  logic [1:0] show_colour;

  assign start_ok    = START && (state_q == ST_IDLE || state_q == ST_WIN || state_q == ST_LOSE);
  assign lfsr_unused = ^lfsr_value[7:2];

  genius_lfsr8 u_lfsr (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .load    (start_ok),
    .seed    (SEED),
    .advance (state_q == ST_APPEND),
    .value   (lfsr_value)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (START) begin
          round_d = '0;
          state_d = ST_APPEND;
        end
      end
      ST_APPEND: begin
        round_d = round_q + 1'b1;
        idx_d   = '0;
        tick_d  = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tick_q == ON_LAST) begin
          tick_d  = '0;
          state_d = ST_SHOW_OFF;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_SHOW_OFF: begin
        if (tick_q == OFF_LAST) begin
          tick_d = '0;
          if (idx_q + 1'b1 == round_q) begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHOW_ON;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_WAIT_IN: begin
        // A press on the final allowed cycle takes priority over the timeout.
        if (BTN_VALID) begin
          if (BTN_CODE == seq_q[idx_q]) begin
            if (idx_q == round_q - 1'b1) begin
              done_d  = 1'b1;
              state_d = (round_q == ROUND_MAX) ? ST_WIN : ST_APPEND;
            end else begin
              idx_d  = idx_q + 1'b1;
              tick_d = '0;
            end
          end else begin
            state_d = ST_LOSE;
          end
        end else if (tick_q == TO_LAST) begin
          state_d = ST_LOSE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // On the first append seq[0] is being written this very cycle, so bypass it from the LFSR.
  always_comb begin
    show_colour = seq_q[idx_d];
    if (state_q == ST_APPEND && round_q == '0) show_colour = lfsr_value[1:0];
    led_d = (state_d == ST_SHOW_ON) ? colour_onehot(show_colour) : 4'b0000;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      idx_q   <= '0;
      tick_q  <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET && state_q == ST_APPEND) seq_q[round_q] <= lfsr_value[1:0];
  end

  assign LED        = led_q;
  assign ROUND      = round_q;
  assign ROUND_DONE = done_q;
  assign PLAYING    = (state_q == ST_APPEND) || (state_q == ST_SHOW_ON) ||
                      (state_q == ST_SHOW_OFF) || (state_q == ST_WAIT_IN);
  assign WIN        = (state_q == ST_WIN);
  assign LOSE       = (state_q == ST_LOSE);

endmodule

`default_nettype wire

// File: tb/tb_genius_round_ctrl.sv
// ---- tb_genius_round_ctrl : self-checking bench for genius_round_ctrl (rev 1.0) ----
`default_nettype none

module tb_genius_round_ctrl;

  localparam int MAXR = 3;
  localparam int TON  = 2;
  localparam int TOFF = 1;
  localparam int TOUT = 20;

  localparam int M_IDLE = 0, M_APPEND = 1, M_SHOW = 2, M_WAIT = 3, M_WIN = 4, M_LOSE = 5;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic [7:0] SEED = 8'h00;
  logic       BTN_VALID = 1'b0;
  logic [1:0] BTN_CODE = 2'b00;
  logic [3:0] LED;
  logic [3:0] ROUND;
  logic       ROUND_DONE, PLAYING, WIN, LOSE;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  genius_round_ctrl #(
    .MAX_ROUND (MAXR),
    .TICKS_ON  (TON),
    .TICKS_OFF (TOFF),
    .TIMEOUT   (TOUT)
  ) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .START      (START),
    .SEED       (SEED),
    .BTN_VALID  (BTN_VALID),
    .BTN_CODE   (BTN_CODE),
    .LED        (LED),
    .ROUND      (ROUND),
    .ROUND_DONE (ROUND_DONE),
    .PLAYING    (PLAYING),
    .WIN        (WIN),
    .LOSE       (LOSE)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: game phase, colour list and a precomputed playback timeline.
  int         m_mode   = M_IDLE;
  int         m_round  = 0;
  int         m_pos    = 0;
  int         m_waited = 0;
  logic [7:0] m_lfsr   = 8'hA5;
  logic [3:0] m_led    = 4'b0;
  logic       m_done   = 1'b0;
  logic [1:0] m_seq [$];
  logic [3:0] m_show [$];

  always @(posedge CLOCK) begin
    m_done = 1'b0;
    m_led  = 4'b0;
    if (!RESET) begin
      m_mode  = M_IDLE;
      m_round = 0;
      m_lfsr  = 8'hA5;
      m_show.delete();
    end else begin
      case (m_mode)
        M_IDLE, M_WIN, M_LOSE: begin
          if (START) begin
            m_lfsr  = (SEED == 8'h00) ? 8'hA5 : SEED;
            m_round = 0;
            m_seq.delete();
            m_mode  = M_APPEND;
          end
        end
        M_APPEND: begin
          m_seq.push_back(m_lfsr[1:0]);
          m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
          m_round++;
          m_show.delete();
          foreach (m_seq[i]) begin
            repeat (TON)  m_show.push_back(4'b0001 << m_seq[i]);
            repeat (TOFF) m_show.push_back(4'b0000);
          end
          m_led  = m_show.pop_front();
          m_mode = M_SHOW;
        end
        M_SHOW: begin
          if (m_show.size() > 0) begin
            m_led = m_show.pop_front();
          end else begin
            m_mode   = M_WAIT;
            m_pos    = 0;
            m_waited = 0;
          end
        end
        M_WAIT: begin
          if (BTN_VALID) begin
            if (BTN_CODE == m_seq[m_pos]) begin
              if (m_pos == m_round - 1) begin
                m_done = 1'b1;
                m_mode = (m_round == MAXR) ? M_WIN : M_APPEND;
              end else begin
                m_pos++;
                m_waited = 0;
              end
            end else begin
              m_mode = M_LOSE;
            end
          end else begin
            m_waited++;
            if (m_waited == TOUT) m_mode = M_LOSE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge CLOCK) begin
    if (cmp_en) begin
      chk("cyc_led",     8'(LED),        8'(m_led));
      chk("cyc_round",   8'(ROUND),      8'(m_round));
      chk("cyc_done",    8'(ROUND_DONE), 8'(m_done));
      chk("cyc_playing", 8'(PLAYING),    8'(m_mode == M_APPEND || m_mode == M_SHOW || m_mode == M_WAIT));
      chk("cyc_win",     8'(WIN),        8'(m_mode == M_WIN));
      chk("cyc_lose",    8'(LOSE),       8'(m_mode == M_LOSE));
    end
  end

  task automatic start_game(input logic [7:0] s);
    START = 1'b1;
    SEED  = s;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    BTN_VALID = 1'b1;
    BTN_CODE  = c;
    @(negedge CLOCK);
    BTN_VALID = 1'b0;
  endtask

  task automatic wait_wait_in();
    int k = 0;
    while (m_mode != M_WAIT && k < 200) begin
      @(negedge CLOCK);
      k++;
    end
    if (m_mode != M_WAIT) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_in_bound: WAIT_IN not reached within 200 cycles");
    end
  endtask

  initial begin
    repeat (2) @(negedge CLOCK);
    cmp_en = 1'b1;
    chk("rst_led",   8'(LED),     8'h0);
    chk("rst_round", 8'(ROUND),   8'h0);
    chk("rst_play",  8'(PLAYING), 8'h0);
    chk("rst_win",   8'(WIN),     8'h0);
    chk("rst_lose",  8'(LOSE),    8'h0);
    RESET = 1'b1;
    @(negedge CLOCK);

    // Round 1 from seed 01: colour 01, 2 cycles lit, 1 dark, then WAIT_IN
    start_game(8'h01);
    chk("app_round0", 8'(ROUND),   8'h0);
    chk("app_play",   8'(PLAYING), 8'h1);
    @(negedge CLOCK);
    chk("r1_round",   8'(ROUND), 8'h1);
    chk("r1_led_a",   8'(LED),   8'h2);
    @(negedge CLOCK);
    chk("r1_led_b",   8'(LED),   8'h2);
    @(negedge CLOCK);
    chk("r1_led_off", 8'(LED),   8'h0);
    @(negedge CLOCK);
    chk("r1_wait_play", 8'(PLAYING), 8'h1);
    wait_wait_in();
    press(2'b01);
    chk("r1_done",  8'(ROUND_DONE), 8'h1);
    @(negedge CLOCK);
    chk("r2_round", 8'(ROUND),      8'h2);
    chk("r2_led0",  8'(LED),        8'h2);
    @(negedge CLOCK);
    @(negedge CLOCK);
    chk("r2_gap",   8'(LED),        8'h0);
    @(negedge CLOCK);
    chk("r2_led1",  8'(LED),        8'h4);

    // Finish rounds 2 and 3 -> WIN
    wait_wait_in();
    press(2'b01);
    press(2'b10);
    wait_wait_in();
    press(2'b01);
    press(2'b10);
    press(2'b00);
    chk("win_flag",  8'(WIN),        8'h1);
    chk("win_round", 8'(ROUND),      8'h3);
    chk("win_play",  8'(PLAYING),    8'h0);
    chk("win_done",  8'(ROUND_DONE), 8'h1);
    repeat (3) @(negedge CLOCK);
    start_game(8'h01);
    chk("restart_win", 8'(WIN), 8'h0);
    @(negedge CLOCK);
    chk("restart_round", 8'(ROUND), 8'h1);

    // Wrong colour in round 2 -> LOSE; START mid-game is ignored
    wait_wait_in();
    press(2'b01);
    wait_wait_in();
    START = 1'b1;
    SEED  = 8'h77;
    @(negedge CLOCK);
    START = 1'b0;
    press(2'b10);
    chk("lose_flag",  8'(LOSE),  8'h1);
    chk("lose_round", 8'(ROUND), 8'h2);
    press(2'b01);
    press(2'b01);
    chk("lose_hold",  8'(LOSE),  8'h1);

    // Timeout: 20 idle cycles in WAIT_IN lose
    start_game(8'h01);
    wait_wait_in();
    repeat (19) @(negedge CLOCK);
    chk("to_before", 8'(LOSE), 8'h0);
    @(negedge CLOCK);
    chk("to_lose",   8'(LOSE), 8'h1);

    // Correct press on the timeout cycle is accepted
    start_game(8'h01);
    wait_wait_in();
    repeat (19) @(negedge CLOCK);
    press(2'b01);
    chk("to_press_done", 8'(ROUND_DONE), 8'h1);
    chk("to_press_lose", 8'(LOSE),       8'h0);

    // Reset during SHOW_ON of round 2, then zero seed
    @(negedge CLOCK);
    chk("mid_led", 8'(LED), 8'h2);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("mr_led",   8'(LED),     8'h0);
    chk("mr_round", 8'(ROUND),   8'h0);
    chk("mr_play",  8'(PLAYING), 8'h0);
    RESET = 1'b1;
    start_game(8'h00);
    @(negedge CLOCK);
    chk("seed0_led",   8'(LED),   8'h2);
    chk("seed0_round", 8'(ROUND), 8'h1);
    wait_wait_in();
    press(2'b01);
    chk("seed0_done", 8'(ROUND_DONE), 8'h1);

    repeat (4) @(negedge CLOCK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
